// File: rtl/speed_gear_display.sv
`default_nettype none
// ============================================================================
// Module      : speed_gear_display
// Description : Dashboard display block. Scans an 8-digit active-low
//               seven-segment display from a packed BCD word, and drives a
//               static single gear digit. Segment order {dp,g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module speed_gear_display #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [2:0]  gear,
    output logic [7:0]  fnd_sel,
    output logic [7:0]  fnd_seg,
    output logic [7:0]  gear_seg
);

    // Clocks per displayed digit; never below one so the scan always advances.
    localparam int c_DIV_RAW = CLK_FREQ / (REFRESH_HZ * 8);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_CNT_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);

    // Active-low segment code; dp stays off, non-decimal nibbles blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_index;
    logic               r_active;
    logic [7:0]         r_sel;

    logic [2:0]         w_index_inc;
    logic [7:0]         w_sel_inc;
    logic [3:0]         w_nibble;

    assign w_index_inc = r_index + 3'd1;
    assign w_sel_inc   = ~(8'h01 << w_index_inc);

    // Scan sequencer: the first cycle out of reset only arms the scan so
    // digit 0 gets its full dwell; afterwards each digit is held c_DIV clocks.
    // The select register is loaded alongside the index to stay in lockstep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_index  <= 3'd0;
            r_active <= 1'b0;
            r_sel    <= 8'hFF;
        end else if (!r_active) begin
            r_active <= 1'b1;
            r_sel    <= 8'hFE;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt    <= '0;
            r_index  <= w_index_inc;
            r_sel    <= w_sel_inc;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Segments follow the live input word so a value change shows at once.
    assign w_nibble = value[{r_index, 2'b00} +: 4];

    assign fnd_sel  = r_sel;
    assign fnd_seg  = r_active ? seg_decode(w_nibble) : 8'hFF;
    assign gear_seg = seg_decode({1'b0, gear});

endmodule
`default_nettype wire

// File: tb/tb_speed_gear_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_speed_gear_display
// Description : Directed bench for speed_gear_display. Instance A runs with
//               one clock per digit, instance B with four clocks per digit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_gear_display;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] value;
    logic [2:0]  gear;
    logic [7:0]  sel_a, seg_a, gseg_a;
    logic [7:0]  sel_b, seg_b, gseg_b;

    int n_checks;
    int n_errors;

    logic [7:0] gear_tab [8];
    logic [7:0] sel_tab  [8];
    logic [7:0] exp_f    [8];

    speed_gear_display #(.CLK_FREQ(16), .REFRESH_HZ(2)) dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .value    (value),
        .gear     (gear),
        .fnd_sel  (sel_a),
        .fnd_seg  (seg_a),
        .gear_seg (gseg_a)
    );

    speed_gear_display #(.CLK_FREQ(64), .REFRESH_HZ(2)) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .value    (value),
        .gear     (gear),
        .fnd_sel  (sel_b),
        .fnd_seg  (seg_b),
        .gear_seg (gseg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        gear_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        sel_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst_a = 1'b1;
        rst_b = 1'b1;
        value = 32'h0000_0073;
        gear  = 3'd0;
        repeat (3) @(negedge clk);

        chk("rst_sel_a", sel_a, 8'hFF);
        chk("rst_seg_a", seg_a, 8'hFF);
        chk("rst_sel_b", sel_b, 8'hFF);
        chk("rst_seg_b", seg_b, 8'hFF);

        // Gear digit is independent of reset.
        for (int g = 0; g < 8; g++) begin
            gear = 3'(g);
            #1;
            chk($sformatf("gear_rst_a%0d", g), gseg_a, gear_tab[g]);
            chk($sformatf("gear_rst_b%0d", g), gseg_b, gear_tab[g]);
        end

        // ---------------- instance A: DIV = 1 ----------------
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        exp_f = '{8'hB0, 8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("a_f1_sel%0d", i), sel_a, sel_tab[i % 8]);
            chk($sformatf("a_f1_seg%0d", i), seg_a, exp_f[i % 8]);
            @(negedge clk);
        end
        // Now on digit 1; change the word mid-frame.
        value = 32'h0000_0049;
        #1;
        chk("a_live_sel", sel_a, 8'hFD);
        chk("a_live_seg", seg_a, 8'h99);
        @(negedge clk);
        repeat (6) @(negedge clk);
        exp_f = '{8'h90, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_f2_sel%0d", i), sel_a, sel_tab[i]);
            chk($sformatf("a_f2_seg%0d", i), seg_a, exp_f[i]);
            @(negedge clk);
        end
        // Non-decimal nibble in digit 2 blanks only that digit.
        value = 32'h0000_0A49;
        exp_f = '{8'h90, 8'h99, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_f3_sel%0d", i), sel_a, sel_tab[i]);
            chk($sformatf("a_f3_seg%0d", i), seg_a, exp_f[i]);
            @(negedge clk);
        end

        gear = 3'd2;
        #1;
        chk("gear2", gseg_a, 8'hA4);
        gear = 3'd5;
        #1;
        chk("gear5", gseg_a, 8'h92);

        // ---------------- instance B: DIV = 4 ----------------
        value = 32'h0000_0073;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        exp_f = '{8'hB0, 8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("b_sel%0d", i), sel_b, sel_tab[(i / 4) % 8]);
            chk($sformatf("b_seg%0d", i), seg_b, exp_f[(i / 4) % 8]);
            @(negedge clk);
        end
        // Move into the middle of digit 2, then reset mid-scan.
        repeat (8) @(negedge clk);
        chk("b_pre_rst_sel", sel_b, 8'hFB);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_mrst_sel0", sel_b, 8'hFF);
        chk("b_mrst_seg0", seg_b, 8'hFF);
        @(negedge clk);
        chk("b_mrst_sel1", sel_b, 8'hFF);
        chk("b_mrst_seg1", seg_b, 8'hFF);
        rst_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b_restart_sel%0d", i), sel_b, (i < 4) ? 8'hFE : 8'hFD);
            chk($sformatf("b_restart_seg%0d", i), seg_b, (i < 4) ? 8'hB0 : 8'hF8);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/speed_gear_display.md
Name: speed_gear_display

Overview:
- Dashboard display block combining two functions.
- An 8-digit time-multiplexed seven-segment (FND) driver shows the packed speed/max-level word.
- A static single-digit driver shows the current gear.
- It sits between the vehicle-state logic (speed, max level, gear) and the board's FND pins. Both functions use active-low segments and the FND driver uses active-low digit selects.

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- REFRESH_HZ, 1000: full 8-digit frame refresh rate in Hz.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- value  input  32  eight 4-bit BCD nibbles; nibble i (value[4i+3:4i]) drives digit i. Digit 0 = speed, digit 1 = max level; the system drives upper nibbles 0.
- gear  input  3  current gear, 0..7.
- fnd_sel  output  8  active-low one-hot digit select; bit i low = digit i on.
- fnd_seg  output  8  active-low segments {dp,g,f,e,d,c,b,a} for the selected digit.
- gear_seg  output  8  active-low segments for the gear digit.

Behaviour:
- Segment code, shared by fnd_seg and gear_seg; bit7 = dp is always 1 (off):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
  - nibble 10..15 = FF (blank)
- DIV = CLK_FREQ / (REFRESH_HZ*8), integer division, clamped to a minimum of 1.
  - Example: CLK_FREQ=16, REFRESH_HZ=2 gives DIV=1, so the digit advances every clock.
- Registered state:
  - tick counter 0..DIV-1
  - 3-bit digit index
  - 1-bit active flag
- Reset (rst=1 at a posedge):
  - counter=0, index=0, active=0.
  - While active=0: fnd_sel=8'hFF and fnd_seg=8'hFF (all off).
- First posedge with rst=0: active goes 1, index stays 0, so digit 0 is shown first.
- While active=1, at each posedge:
  - If counter==DIV-1: counter goes to 0 and index goes to index+1 mod 8 (7 wraps to 0).
  - Otherwise counter increments.
- Select output: fnd_sel = ~(8'b1 << index), registered, and exactly one bit is low while active.
- Segment output: fnd_seg = decode(value nibble[index]).
  - Purely combinational from value and the current index, with zero latency.
  - A value change is visible on the very next displayed digit; no stale frame.
- Each digit is held for DIV consecutive cycles; a full frame takes 8*DIV cycles.
- Reset asserted mid-scan: the next posedge blanks the outputs and restarts scanning at digit 0.
- gear_seg = decode({1'b0, gear}): purely combinational and unaffected by rst or the scan state.
- No handshake; inputs are sampled continuously.

Test Plan:
- Parameters CLK_FREQ=16, REFRESH_HZ=2. Hold rst=1, then release at a clock edge. During reset fnd_sel=FF and fnd_seg=FF. After release, digit 0 (fnd_sel=FE) appears first and fnd_sel steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, one step per clock.
- value={24'd0,4'd7,4'd3}. Capture one full frame: digit0=B0 (3), digit1=F8 (7), digits 2..7=C0 (0).
- Change value to {24'd0,4'd4,4'd9} mid-frame. The next captured frame shows digit0=90 and digit1=99 (digit1 is 4, code 99), with digits 2..7=C0.
- gear 2 gives gear_seg=A4; gear 5 gives gear_seg=92. Sweep gear 0..7 and check each against the code table, including while rst=1.
- DIV>1 case, CLK_FREQ=64, REFRESH_HZ=2 (DIV=4): each fnd_sel pattern is held for exactly 4 clocks and the frame is 32 clocks. Assert rst mid-frame: blank for the reset cycles, then restart at FE.
- value nibble 0xA in digit 2: that digit's fnd_seg=FF while other digits are unaffected.
